// File: rtl/rpn_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rpn_exec: command executor feeding an RPN operand stack (push/pop/compute). |
// | Optional macro RPN_EXEC_SAT_EN: saturating ADD/SUB/MUL instead of wrapping. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rpn_exec #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_wdata,
  input  logic [DATA_W-1:0] stk_rdata,
  input  logic              stk_full,
  input  logic              stk_empty,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              ovf,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  depth
);

  localparam logic [2:0] c_OP_PUSH = 3'b000;
  localparam logic [2:0] c_OP_ADD  = 3'b001;
  localparam logic [2:0] c_OP_SUB  = 3'b010;
  localparam logic [2:0] c_OP_MUL  = 3'b011;
  localparam logic [2:0] c_OP_AND  = 3'b100;
  localparam logic [2:0] c_OP_OR   = 3'b101;
  localparam logic [2:0] c_OP_XOR  = 3'b110;
  localparam logic [2:0] c_OP_DUP  = 3'b111;

  localparam logic [1:0] c_ERR_UNDER = 2'b01;
  localparam logic [1:0] c_ERR_OVER  = 2'b10;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    WRITE   = 4'd1,
    POP_B   = 4'd2,
    POP_A   = 4'd3,
    CAP_A   = 4'd4,
    DUP_POP = 4'd5,
    DUP_CAP = 4'd6,
    DUP_W2  = 4'd7,
    ERR     = 4'd8
  } state_t;

  state_t             r_state, w_state;
  logic [2:0]         r_op, w_op;
  logic [DATA_W-1:0]  r_b, w_b;
  logic [DATA_W-1:0]  r_wdata, w_wdata;
  logic               r_push, w_push;
  logic               r_pop, w_pop;
  logic               r_err, w_err;
  logic               r_ovf, w_ovf;
  logic [1:0]         r_code, w_code;
  logic [CNT_W-1:0]   r_depth;

  logic [DATA_W:0]    w_sum, w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]  w_alu;
  logic               w_alu_ovf;
  logic               w_full, w_none, w_lt2;

  assign w_full = (r_depth == CNT_W'(DEPTH)) || stk_full;
  assign w_none = (r_depth == '0) || stk_empty;
  assign w_lt2  = (r_depth < CNT_W'(2)) || stk_empty;

  // A arrives on stk_rdata during CAP_A; B was captured one cycle earlier.
  always_comb begin
    w_sum     = {1'b0, stk_rdata} + {1'b0, r_b};
    w_diff    = {1'b0, stk_rdata} - {1'b0, r_b};
    w_prod    = {{DATA_W{1'b0}}, stk_rdata} * {{DATA_W{1'b0}}, r_b};
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_alu_ovf = w_sum[DATA_W];
`ifdef RPN_EXEC_SAT_EN
        w_alu = w_alu_ovf ? '1 : w_sum[DATA_W-1:0];
`else
        w_alu = w_sum[DATA_W-1:0];
`endif
      end
      c_OP_SUB: begin
        w_alu_ovf = w_diff[DATA_W];
`ifdef RPN_EXEC_SAT_EN
        w_alu = w_alu_ovf ? '0 : w_diff[DATA_W-1:0];
`else
        w_alu = w_diff[DATA_W-1:0];
`endif
      end
      c_OP_MUL: begin
        w_alu_ovf = |w_prod[2*DATA_W-1:DATA_W];
`ifdef RPN_EXEC_SAT_EN
        w_alu = w_alu_ovf ? '1 : w_prod[DATA_W-1:0];
`else
        w_alu = w_prod[DATA_W-1:0];
`endif
      end
      c_OP_AND: w_alu = stk_rdata & r_b;
      c_OP_OR:  w_alu = stk_rdata | r_b;
      c_OP_XOR: w_alu = stk_rdata ^ r_b;
      default:  w_alu = '0;
    endcase
  end

  // Next-state and next-output values; every output is registered from these.
  always_comb begin
    w_state = r_state;
    w_op    = r_op;
    w_b     = r_b;
    w_wdata = r_wdata;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_err   = 1'b0;
    w_ovf   = r_ovf;
    w_code  = r_code;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_op = cmd_op;
          case (cmd_op)
            c_OP_PUSH: begin
              if (w_full) begin
                w_state = ERR; w_err = 1'b1; w_code = c_ERR_OVER;
              end else begin
                w_state = WRITE; w_push = 1'b1; w_wdata = cmd_data;
              end
            end
            c_OP_DUP: begin
              if (w_none) begin
                w_state = ERR; w_err = 1'b1; w_code = c_ERR_UNDER;
              end else if (w_full) begin
                w_state = ERR; w_err = 1'b1; w_code = c_ERR_OVER;
              end else begin
                w_state = DUP_POP; w_pop = 1'b1;
              end
            end
            default: begin
              if (w_lt2) begin
                w_state = ERR; w_err = 1'b1; w_code = c_ERR_UNDER;
              end else begin
                w_state = POP_B; w_pop = 1'b1;
              end
            end
          endcase
        end
      end
      POP_B: begin
        w_state = POP_A;
        w_pop   = 1'b1;
      end
      POP_A: begin
        w_state = CAP_A;
        w_b     = stk_rdata;
      end
      CAP_A: begin
        w_state = WRITE;
        w_push  = 1'b1;
        w_wdata = w_alu;
        w_ovf   = w_alu_ovf;
      end
      DUP_POP: w_state = DUP_CAP;
      DUP_CAP: begin
        w_state = WRITE;
        w_push  = 1'b1;
        w_wdata = stk_rdata;
        w_ovf   = 1'b0;
      end
      WRITE: begin
        if (r_op == c_OP_DUP) begin
          w_state = DUP_W2;
          w_push  = 1'b1;
        end else begin
          w_state = IDLE;
        end
      end
      DUP_W2:  w_state = IDLE;
      ERR:     w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_b     <= '0;
      r_wdata <= '0;
      r_push  <= 1'b0;
      r_pop   <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      r_code  <= '0;
      r_depth <= '0;
    end else begin
      r_state <= w_state;
      r_op    <= w_op;
      r_b     <= w_b;
      r_wdata <= w_wdata;
      r_push  <= w_push;
      r_pop   <= w_pop;
      r_err   <= w_err;
      r_ovf   <= w_ovf;
      r_code  <= w_code;
      if (r_push)
        r_depth <= r_depth + CNT_W'(1);
      else if (r_pop)
        r_depth <= r_depth - CNT_W'(1);
    end
  end

  assign cmd_ready    = (r_state == IDLE) && !reset;
  assign stk_push     = r_push;
  assign stk_pop      = r_pop;
  assign stk_wdata    = r_wdata;
  assign result       = r_wdata;
  assign result_valid = r_push;
  assign ovf          = r_ovf;
  assign err          = r_err;
  assign err_code     = r_code;
  assign depth        = r_depth;

endmodule
`default_nettype wire

// File: tb/tb_rpn_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rpn_exec: table vectors, corner sequences and random commands checked   |
// | against a queue-based RPN calculator model. Revision: 1.0                  |
// +----------------------------------------------------------------------------+
module tb_rpn_exec;
  localparam int DW = 4;
  localparam int DP = 64;
  localparam int CW = 7;
`ifdef RPN_EXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready, stk_push, stk_pop, stk_full, stk_empty;
  logic [DW-1:0] stk_wdata, result;
  logic [DW-1:0] stk_rdata = '0;
  logic          result_valid, ovf, err;
  logic [1:0]    err_code;
  logic [CW-1:0] depth;

  rpn_exec #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .stk_push(stk_push),
    .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .stk_full(stk_full), .stk_empty(stk_empty), .result(result),
    .result_valid(result_valid), .ovf(ovf), .err(err), .err_code(err_code),
    .depth(depth)
  );

  always #5 clk = ~clk;

  // Operand stack environment: read data is valid the cycle after a pop.
  logic [DW-1:0] env_mem [DP];
  int env_sp = 0;
  int overlap = 0;
  always @(posedge clk) begin
    if (stk_push && stk_pop) overlap <= overlap + 1;
    if (reset) begin
      env_sp <= 0;
    end else if (stk_push && env_sp < DP) begin
      env_mem[env_sp] <= stk_wdata;
      env_sp <= env_sp + 1;
    end else if (stk_pop && env_sp > 0) begin
      stk_rdata <= env_mem[env_sp-1];
      env_sp <= env_sp - 1;
    end
  end
  assign stk_full  = (env_sp == DP);
  assign stk_empty = (env_sp == 0);

  typedef struct {
    logic [2:0] op;
    logic [3:0] data;
    logic       err;
    logic [1:0] code;
    logic [3:0] res;
    logic       ovf;
    int         depth;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic vec_t mk(int op, int d, int e, int code, int res, int ov, int dep);
    vec_t v;
    v.op = 3'(op); v.data = 4'(d); v.err = e[0]; v.code = 2'(code);
    v.res = 4'(res); v.ovf = ov[0]; v.depth = dep;
    return v;
  endfunction

  // Reference calculator: plain integer arithmetic on a queue.
  int mstk[$];
  task automatic model_step(input logic [2:0] op, input logic [3:0] d, output vec_t e);
    int a, b, r;
    bit ov;
    e = mk(op, d, 0, 0, 0, 0, 0);
    if (op == 3'd0) begin
      if (mstk.size() == DP) begin e.err = 1; e.code = 2; end
      else begin mstk.push_back(d); e.res = d; end
    end else if (op == 3'd7) begin
      if (mstk.size() == 0) begin e.err = 1; e.code = 1; end
      else if (mstk.size() == DP) begin e.err = 1; e.code = 2; end
      else begin r = mstk[$]; mstk.push_back(r); e.res = 4'(r); end
    end else if (mstk.size() < 2) begin
      e.err = 1; e.code = 1;
    end else begin
      b = mstk.pop_back();
      a = mstk.pop_back();
      ov = 0;
      case (op)
        3'd1: begin r = a + b; ov = (r > 15); if (ov) r = SAT ? 15 : r - 16; end
        3'd2: begin ov = (a < b); r = ov ? (SAT ? 0 : a - b + 16) : a - b; end
        3'd3: begin r = a * b; ov = (r > 15); if (ov) r = SAT ? 15 : r % 16; end
        3'd4: r = a & b;
        3'd5: r = a | b;
        default: r = a ^ b;
      endcase
      mstk.push_back(r);
      e.res = 4'(r); e.ovf = ov;
    end
    e.depth = mstk.size();
  endtask

  int push_mask, pop_mask, err_mask, rv_mask, rdy_off, np;
  logic [3:0] pdata [2];

  // Issue one command at a negedge and record strobes for cycles T+1..T+6.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d);
    int w = 0;
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    push_mask = 0; pop_mask = 0; err_mask = 0; rv_mask = 0; rdy_off = 0; np = 0;
    pdata[0] = '0; pdata[1] = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 4'($urandom);
      end
      if (stk_push) begin
        push_mask |= (1 << k);
        if (np < 2) pdata[np] = stk_wdata;
        np++;
      end
      if (stk_pop) pop_mask |= (1 << k);
      if (err) err_mask |= (1 << k);
      if (result_valid) rv_mask |= (1 << k);
      if (cmd_ready && rdy_off == 0) rdy_off = k;
    end
  endtask

  task automatic verify(input vec_t e);
    int ep, eq, er;
    if (e.err) begin
      chk("err_pulse", err_mask, 2);
      chk("err_code", err_code, e.code);
      chk("err_no_push", push_mask, 0);
      chk("err_no_pop", pop_mask, 0);
      chk("err_ready", rdy_off, 2);
    end else begin
      if (e.op == 3'd0)      begin ep = 2;  eq = 0; er = 2; end
      else if (e.op == 3'd7) begin ep = 24; eq = 2; er = 5; end
      else                   begin ep = 16; eq = 6; er = 5; end
      chk("no_err", err_mask, 0);
      chk("push_timing", push_mask, ep);
      chk("pop_timing", pop_mask, eq);
      chk("result_valid_timing", rv_mask, ep);
      chk("ready_timing", rdy_off, er);
      chk("push_data", pdata[0], e.res);
      if (e.op == 3'd7) chk("dup_push2_data", pdata[1], e.res);
      chk("result", result, e.res);
      if (e.op != 3'd0) chk("ovf", ovf, e.ovf);
    end
    chk("depth", depth, e.depth);
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [3:0] d);
    vec_t e;
    model_step(op, d, e);
    run_cmd(op, d);
    verify(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_push", stk_push, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_depth", depth, 0);
    chk("rst_result", result, 0);
    chk("rst_wdata", stk_wdata, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_rv", result_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    mstk.delete();
  endtask

  vec_t tbl [16];
  int pushes;
  logic [2:0] rop;
  int rr;

  initial begin
    tbl[0]  = mk(0, 3, 0, 0, 3, 0, 1);
    tbl[1]  = mk(0, 5, 0, 0, 5, 0, 2);
    tbl[2]  = mk(1, 0, 0, 0, 8, 0, 1);
    tbl[3]  = mk(0, 2, 0, 0, 2, 0, 2);
    tbl[4]  = mk(0, 5, 0, 0, 5, 0, 3);
    tbl[5]  = mk(2, 0, 0, 0, SAT ? 0 : 13, 1, 2);
    tbl[6]  = mk(0, 6, 0, 0, 6, 0, 3);
    tbl[7]  = mk(0, 3, 0, 0, 3, 0, 4);
    tbl[8]  = mk(3, 0, 0, 0, SAT ? 15 : 2, 1, 3);
    tbl[9]  = mk(6, 0, 0, 0, 15, 0, 2);
    tbl[10] = mk(4, 0, 0, 0, 8, 0, 1);
    tbl[11] = mk(7, 0, 0, 0, 8, 0, 2);
    tbl[12] = mk(5, 0, 0, 0, 8, 0, 1);
    tbl[13] = mk(1, 0, 1, 1, 0, 0, 1);
    tbl[14] = mk(0, 9, 0, 0, 9, 0, 2);
    tbl[15] = mk(1, 0, 0, 0, SAT ? 15 : 1, 1, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_cmd(tbl[i].op, tbl[i].data);
      verify(tbl[i]);
    end

    // Underflow from empty, then DUP.
    do_reset();
    model_cmd(3'd1, 4'd0);
    model_cmd(3'd0, 4'd7);
    model_cmd(3'd7, 4'd0);

    // Fill to capacity, then overflow on PUSH and DUP, then a normal op.
    do_reset();
    for (int i = 0; i < DP; i++) model_cmd(3'd0, 4'($urandom));
    model_cmd(3'd0, 4'd1);
    model_cmd(3'd7, 4'd0);
    model_cmd(3'd1, 4'd0);

    // Reset in the middle of a binary op.
    do_reset();
    model_cmd(3'd0, 4'd4);
    model_cmd(3'd0, 4'd9);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("midrst_pop1", stk_pop, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_depth", depth, 0);
    chk("midrst_push", stk_push, 0);
    chk("midrst_ready_in_reset", cmd_ready, 0);
    chk("midrst_result", result, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    pushes = 0;
    for (int k = 0; k < 5; k++) begin
      if (stk_push) pushes++;
      @(negedge clk);
    end
    chk("midrst_no_push", pushes, 0);
    mstk.delete();

    // Random commands against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rr = $urandom_range(0, 10);
      rop = (rr < 4) ? 3'd0 : 3'(rr - 3);
      model_cmd(rop, 4'($urandom));
    end

    chk("no_push_pop_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
